// File: rtl/sam_stream_pkg.sv
// Shared token format and FSM state definitions for the sparse stream blocks.
package sam_stream_pkg;
  localparam int TOK_W   = 17;
  localparam int CTL_BIT = 16;
  localparam logic [TOK_W-1:0] DONE_TOK = 17'h10100;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    REPEAT   = 2'd1,
    DONE_OUT = 2'd2
  } rep_state_t;

  function automatic logic tok_is_done(input logic [TOK_W-1:0] t);
    return t[CTL_BIT] && (t[9:8] == 2'b01);
  endfunction

  function automatic logic [TOK_W-1:0] stop_tok(input logic [7:0] lvl);
    return {1'b1, 8'h00, lvl};
  endfunction
endpackage

// File: rtl/reg_fifo_2.sv
// Two-entry register FIFO; a push into a full FIFO is refused even if a pop happens that cycle.
module reg_fifo_2 #(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/stream_repeater.sv
// Replays each reference data token once per "R" on the repeat-signal stream,
// re-levels stop tokens and forwards DONE, all through a 2-entry output FIFO.
module stream_repeater
  import sam_stream_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             tile_en,
  input  logic [TOK_W-1:0] proj_data_in,
  input  logic             proj_data_in_valid,
  output logic             proj_data_in_ready,
  input  logic [TOK_W-1:0] repsig_data_in,
  input  logic             repsig_data_in_valid,
  output logic             repsig_data_in_ready,
  output logic [TOK_W-1:0] ref_data_out,
  output logic             ref_data_out_valid,
  input  logic             ref_data_out_ready
);
  rep_state_t       state_q;
  logic [15:0]      held_q;
  logic             pending_q;
  logic             err_q;

  logic             en;
  logic             room;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic [TOK_W-1:0] push_tok;
  logic             ref_pop;
  logic             rep_pop;
  logic             ref_done;
  logic             ref_stop;
  logic             rep_done;
  logic             rep_unused;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Reset also gates the handshakes so nothing is offered while rst_n is low.
  assign en         = clk_en && tile_en && rst_n;
  assign room       = !fifo_full;
  assign ref_done   = tok_is_done(proj_data_in);
  assign ref_stop   = proj_data_in[CTL_BIT] && !ref_done;
  assign rep_done   = tok_is_done(repsig_data_in);
  assign rep_unused = ^{repsig_data_in[15:10], repsig_data_in[7:0]};

  always_comb begin
    push     = 1'b0;
    push_tok = stop_tok(8'h00);
    ref_pop  = 1'b0;
    rep_pop  = 1'b0;
    if (en) begin
      case (state_q)
        FETCH: begin
          if (proj_data_in_valid && !proj_data_in[CTL_BIT]) begin
            if (pending_q) push = room;
            else           ref_pop = room;
          end else if (proj_data_in_valid && ref_stop) begin
            push     = room;
            push_tok = stop_tok(sat_inc(proj_data_in[7:0]));
            ref_pop  = room;
          end else if (proj_data_in_valid && ref_done && repsig_data_in_valid && rep_done) begin
            if (pending_q) begin
              push = room;
            end else begin
              ref_pop = 1'b1;
              rep_pop = 1'b1;
            end
          end
        end
        REPEAT: begin
          // A protocol error quiesces the repeat side until reset.
          if (repsig_data_in_valid && !err_q) begin
            if (!repsig_data_in[CTL_BIT]) begin
              push     = room;
              push_tok = {1'b0, held_q};
              rep_pop  = room;
            end else if (!rep_done) begin
              rep_pop = 1'b1;
            end
          end
        end
        DONE_OUT: begin
          push     = room;
          push_tok = DONE_TOK;
        end
        default: ;
      endcase
    end
  end

  assign proj_data_in_ready   = ref_pop;
  assign repsig_data_in_ready = rep_pop;
  assign ref_data_out_valid   = en && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      held_q    <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (en) begin
      case (state_q)
        FETCH: begin
          if (push) pending_q <= 1'b0;
          if (ref_pop && !proj_data_in[CTL_BIT]) begin
            held_q  <= proj_data_in[15:0];
            state_q <= REPEAT;
          end else if (ref_pop && ref_done) begin
            state_q <= DONE_OUT;
          end
        end
        REPEAT: begin
          if (repsig_data_in_valid && rep_done) err_q <= 1'b1;
          if (rep_pop && repsig_data_in[CTL_BIT]) begin
            pending_q <= 1'b1;
            state_q   <= FETCH;
          end
        end
        DONE_OUT: begin
          if (push) begin
            pending_q <= 1'b0;
            state_q   <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  reg_fifo_2 #(.DATA_W(TOK_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_tok),
    .pop      (ref_data_out_valid && ref_data_out_ready),
    .head     (ref_data_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule
